// File: rtl/seven_seg_capture.sv
// seven_seg_capture: qualifies scanned 4-digit seven-segment patterns and rebuilds hex frames
module seven_seg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       an0,
    input  logic       an1,
    input  logic       an2,
    input  logic       an3,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       frame_valid,
    output logic       pattern_err,
    output logic       stale,
    output logic [7:0] err_count
);
    typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;

    state_t          state_q, state_d;
    logic [6:0]      seg_q, seg_d, pat_q, pat_d;
    logic [3:0]      an_q, an_d, sel_q, sel_d;
    logic [7:0]      stab_q, stab_d;
    logic [3:0]      valid_q, valid_d;
    logic [3:0][3:0] shadow_q, shadow_d, digit_q, digit_d;
    logic [15:0]     to_q, to_d;
    logic            stale_q, stale_d, fv_q, fv_d, perr_q, perr_d;
    logic [7:0]      err_q, err_d;
    logic            one_hot, same, restart, cap, legal, complete, timeout;
    logic [3:0]      val;
    logic [1:0]      slot;

    // {legal, value} for an active-low a..g glyph
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0000001: decode = 5'h10;
            7'b1001111: decode = 5'h11;
            7'b0010010: decode = 5'h12;
            7'b0000110: decode = 5'h13;
            7'b1001100: decode = 5'h14;
            7'b0100100: decode = 5'h15;
            7'b0100000: decode = 5'h16;
            7'b0001111: decode = 5'h17;
            7'b0000000: decode = 5'h18;
            7'b0000100: decode = 5'h19;
            7'b0001000: decode = 5'h1A;
            7'b1100000: decode = 5'h1B;
            7'b0110001: decode = 5'h1C;
            7'b1000010: decode = 5'h1D;
            7'b0110000: decode = 5'h1E;
            7'b0111000: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    // Slot qualification FSM: a capture fires on the STABLE_CYCLES-th identical registered sample
    always_comb begin
        seg_d   = {a, b, c, d, e, f, g};
        an_d    = {an3, an2, an1, an0};
        one_hot = $onehot(~an_q);
        same    = (seg_q == pat_q) && (an_q == sel_q);
        state_d = state_q;
        pat_d   = pat_q;
        sel_d   = sel_q;
        stab_d  = stab_q;
        cap     = 1'b0;
        restart = 1'b0;
        case (state_q)
            IDLE: restart = one_hot;
            QUAL: begin
                if (same) begin
                    stab_d = stab_q + 8'd1;
                    if ({1'b0, stab_q} + 9'd1 >= 9'(STABLE_CYCLES)) begin
                        cap     = 1'b1;
                        state_d = HOLD;
                    end
                end else begin
                    restart = one_hot;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (!same) begin
                    restart = one_hot;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (restart) begin
            state_d = (STABLE_CYCLES == 1) ? HOLD : QUAL;
            cap     = (STABLE_CYCLES == 1);
            pat_d   = seg_q;
            sel_d   = an_q;
            stab_d  = 8'd1;
        end
    end

    // Capture, frame assembly and partial-frame timeout; completion beats timeout
    always_comb begin
        {legal, val} = decode(seg_q);
        slot     = !an_q[0] ? 2'd0 : !an_q[1] ? 2'd1 : !an_q[2] ? 2'd2 : 2'd3;
        complete = &valid_q;
        timeout  = !complete && (|valid_q) && ({1'b0, to_q} + 17'd1 == 17'(TIMEOUT_CYCLES));
        valid_d  = (complete || timeout) ? 4'b0 : valid_q;
        shadow_d = shadow_q;
        if (cap && legal) begin
            shadow_d[slot] = val;
            valid_d[slot]  = 1'b1;
        end
        to_d    = ((|valid_q) && !complete && !timeout) ? to_q + 16'd1 : 16'd0;
        digit_d = complete ? shadow_q : digit_q;
        fv_d    = complete;
        perr_d  = cap && !legal;
        err_d   = (perr_d && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        stale_d = stale_q | timeout;
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            seg_q    <= '0;
            an_q     <= '0;
            pat_q    <= '0;
            sel_q    <= '0;
            stab_q   <= '0;
            valid_q  <= '0;
            shadow_q <= '0;
            digit_q  <= '0;
            to_q     <= '0;
            stale_q  <= 1'b0;
            fv_q     <= 1'b0;
            perr_q   <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            pat_q    <= pat_d;
            sel_q    <= sel_d;
            stab_q   <= stab_d;
            valid_q  <= valid_d;
            shadow_q <= shadow_d;
            digit_q  <= digit_d;
            to_q     <= to_d;
            stale_q  <= stale_d;
            fv_q     <= fv_d;
            perr_q   <= perr_d;
            err_q    <= err_d;
        end
    end

    assign digit0      = digit_q[0];
    assign digit1      = digit_q[1];
    assign digit2      = digit_q[2];
    assign digit3      = digit_q[3];
    assign frame_valid = fv_q;
    assign pattern_err = perr_q;
    assign stale       = stale_q;
    assign err_count   = err_q;
endmodule
